// File: rtl/snail_match_counter_if.sv
// Handshake/data bundle between the windowed match counter and its
// surroundings: detector match in, start/ack control in, status and result out.
interface snail_match_counter_if #(
  parameter int CNT_W = 8
);
  logic             match;
  logic             start;
  logic             ack;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] result;
  logic             alarm;

  modport master (
    output match, start, ack,
    input  busy, result_valid, result, alarm
  );

  modport slave (
    input  match, start, ack,
    output busy, result_valid, result, alarm
  );
endinterface

// File: rtl/snail_match_counter.sv
// Windowed match counter downstream of the serial 010 detector.
// On start it counts detector match events for WINDOW cycles, then latches a
// saturated total plus a threshold alarm and holds them under valid/ack.
// Optional feature macro SNAIL_CNT_EDGE_EN: when defined, an event is a rising
// edge of match; when undefined, every cycle with match high is an event.
module snail_match_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 64,
  parameter int THRESH = 3
) (
  input  logic                    clk,
  input  logic                    _rst,
  snail_match_counter_if.slave    bus
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [31:0] THRESH_U = THRESH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [WIN_W-1:0] win;
  logic             ev;

`ifdef SNAIL_CNT_EDGE_EN
  logic match_q;

  // Previous-cycle match, tracked in every state so the first RUN sample
  // sees the value present on the start edge.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) match_q <= 1'b0;
    else       match_q <= bus.match;
  end
`endif

  // Event qualification and saturating next count.
  always_comb begin
`ifdef SNAIL_CNT_EDGE_EN
    ev = bus.match & ~match_q;
`else
    ev = bus.match;
`endif
    cnt_next = cnt;
    if (ev && (cnt != '1)) cnt_next = cnt + 1'b1;
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state            <= IDLE;
      cnt              <= '0;
      win              <= '0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result       <= '0;
      bus.alarm        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            cnt      <= '0;
            win      <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt_next;
          win <= win + 1'b1;
          if (win == WIN_LAST) begin
            state            <= DONE;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b1;
            bus.result       <= cnt_next;
            bus.alarm        <= (32'(cnt_next) >= THRESH_U);
          end
        end
        DONE: begin
          if (bus.ack) begin
            state            <= IDLE;
            bus.result_valid <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          bus.busy         <= 1'b0;
          bus.result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snail_match_counter.sv
// Self-checking bench for snail_match_counter: three instances cover the
// 16-cycle window, a 4-bit saturating counter and the single-cycle window.
module tb_snail_match_counter;

  localparam int CA = 8, WA = 16;
  localparam int CB = 4, WB = 32;
  localparam int CC = 8, WC = 1;
  localparam int TH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] exp_res;
  logic [31:0] exp_alm;

  snail_match_counter_if #(.CNT_W(CA)) ia ();
  snail_match_counter_if #(.CNT_W(CB)) ib ();
  snail_match_counter_if #(.CNT_W(CC)) ic ();

  snail_match_counter #(.CNT_W(CA), .WINDOW(WA), .THRESH(TH)) dut_a (
    .clk(clk), ._rst(rst_n), .bus(ia));
  snail_match_counter #(.CNT_W(CB), .WINDOW(WB), .THRESH(TH)) dut_b (
    .clk(clk), ._rst(rst_n), .bus(ib));
  snail_match_counter #(.CNT_W(CC), .WINDOW(WC), .THRESH(TH)) dut_c (
    .clk(clk), ._rst(rst_n), .bus(ic));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Reference: number of events in a window, saturated to the counter width.
  function automatic logic [31:0] model(input logic prev, input logic [63:0] pat,
                                        input int unsigned n, input int unsigned cntw);
    longint unsigned lvl = 0;
    longint unsigned edg = 0;
    longint unsigned top = (64'd1 << cntw) - 1;
    logic p = prev;
    for (int unsigned i = 0; i < n; i++) begin
      if (pat[i]) lvl++;
      if (pat[i] && !p) edg++;
      p = pat[i];
    end
`ifdef SNAIL_CNT_EDGE_EN
    return 32'((edg > top) ? top : edg);
`else
    return 32'((lvl > top) ? top : lvl);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic m0);
    ia.start = 1'b1;
    ia.match = m0;
    ia.ack   = 1'b0;
    step();
    chk("a_start_busy", 32'(ia.busy), 1);
    chk("a_start_valid", 32'(ia.result_valid), 0);
    ia.start = 1'b0;
  endtask

  task automatic run_a(input logic m0, input logic [WA-1:0] pat);
    exp_res = model(m0, 64'(pat), WA, CA);
    exp_alm = (exp_res >= TH) ? 1 : 0;
    for (int i = 0; i < WA; i++) begin
      ia.match = pat[i];
      ia.start = 1'($urandom);
      step();
      if (i < WA - 1) begin
        chk("a_run_busy", 32'(ia.busy), 1);
        chk("a_run_valid", 32'(ia.result_valid), 0);
      end else begin
        chk("a_end_busy", 32'(ia.busy), 0);
        chk("a_end_valid", 32'(ia.result_valid), 1);
        chk("a_end_result", 32'(ia.result), exp_res);
        chk("a_end_alarm", 32'(ia.alarm), exp_alm);
      end
    end
    ia.start = 1'b0;
  endtask

  task automatic ack_a(input logic st);
    ia.ack   = 1'b1;
    ia.start = st;
    ia.match = 1'($urandom);
    step();
    chk("a_ack_valid", 32'(ia.result_valid), 0);
    chk("a_ack_busy", 32'(ia.busy), 0);
    chk("a_ack_result_kept", 32'(ia.result), exp_res);
    chk("a_ack_alarm_kept", 32'(ia.alarm), exp_alm);
    ia.ack   = 1'b0;
    ia.start = 1'b0;
  endtask

  initial begin
    logic [WA-1:0] pat;
    logic          m0;
    logic [63:0]   ones;

    ia.match = 1'($urandom); ia.start = 1'($urandom); ia.ack = 1'($urandom);
    ib.match = 1'b0; ib.start = 1'b0; ib.ack = 1'b0;
    ic.match = 1'b0; ic.start = 1'b0; ic.ack = 1'b0;

    // Power-on reset asserted mid-cycle with random inputs.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_busy", 32'(ia.busy), 0);
    chk("rst_a_valid", 32'(ia.result_valid), 0);
    chk("rst_a_result", 32'(ia.result), 0);
    chk("rst_a_alarm", 32'(ia.alarm), 0);
    chk("rst_b_busy", 32'(ib.busy), 0);
    chk("rst_c_valid", 32'(ic.result_valid), 0);
    step();
    step();
    ia.start = 1'b0; ia.ack = 1'b0; ia.match = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_busy", 32'(ia.busy), 0);
      chk("idle_valid", 32'(ia.result_valid), 0);
    end

    // Matches at RUN cycles 0, 5 and 15.
    pat = '0;
    pat[0] = 1'b1; pat[5] = 1'b1; pat[15] = 1'b1;
    start_a(1'b0);
    run_a(1'b0, pat);
    chk("dir3_result", 32'(ia.result), 3);
    chk("dir3_alarm", 32'(ia.alarm), 1);

    // DONE holds for 10 cycles while start/match toggle.
    for (int i = 0; i < 10; i++) begin
      ia.start = 1'($urandom);
      ia.match = 1'($urandom);
      step();
      chk("hold_valid", 32'(ia.result_valid), 1);
      chk("hold_result", 32'(ia.result), exp_res);
      chk("hold_alarm", 32'(ia.alarm), exp_alm);
      chk("hold_busy", 32'(ia.busy), 0);
    end
    // ack and start together: ack wins, start dropped.
    ack_a(1'b1);
    start_a(1'b0);
    pat = 16'($urandom);
    run_a(1'b0, pat);
    ack_a(1'b0);

    // Randomized windows against the reference model.
    for (int w = 0; w < 10; w++) begin
      m0  = 1'($urandom);
      pat = (w % 2 == 0) ? 16'($urandom) : 16'($urandom & $urandom);
      if (w == 9) pat = '1;
      start_a(m0);
      run_a(m0, pat);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        ia.match = 1'($urandom);
        step();
        chk("rnd_hold_valid", 32'(ia.result_valid), 1);
      end
      ack_a(1'($urandom));
      ia.match = 1'($urandom);
      step();
      chk("rnd_idle_busy", 32'(ia.busy), 0);
    end

    // Reset at RUN cycle 7 after two matches; old count must be lost.
    start_a(1'b0);
    for (int i = 0; i < 7; i++) begin
      ia.match = (i == 1 || i == 4);
      step();
    end
    #3;
    ia.match = 1'($urandom); ia.start = 1'($urandom); ia.ack = 1'($urandom);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(ia.busy), 0);
    chk("midrst_valid", 32'(ia.result_valid), 0);
    chk("midrst_result", 32'(ia.result), 0);
    chk("midrst_alarm", 32'(ia.alarm), 0);
    step();
    ia.start = 1'b0; ia.ack = 1'b0; ia.match = 1'b0;
    rst_n = 1'b1;
    step();
    chk("postrst_busy", 32'(ia.busy), 0);
    pat = '0;
    pat[3] = 1'b1;
    start_a(1'b0);
    run_a(1'b0, pat);
    chk("postrst_result", 32'(ia.result), 1);
    ack_a(1'b0);

    // 4-bit counter, match held high for a 32-cycle window.
    ib.start = 1'b1; ib.match = 1'b0;
    step();
    chk("b_start_busy", 32'(ib.busy), 1);
    ib.start = 1'b0;
    ib.match = 1'b1;
    for (int i = 0; i < WB; i++) step();
    ones = 64'hFFFF_FFFF;
    exp_res = model(1'b0, ones, WB, CB);
    chk("b_sat_valid", 32'(ib.result_valid), 1);
    chk("b_sat_result", 32'(ib.result), exp_res);
    chk("b_sat_alarm", 32'(ib.alarm), (exp_res >= TH) ? 1 : 0);
    ib.match = 1'b0;
    ib.ack = 1'b1;
    step();
    chk("b_ack_valid", 32'(ib.result_valid), 0);
    ib.ack = 1'b0;

    // Single-cycle window.
    ic.start = 1'b1; ic.match = 1'b0;
    step();
    chk("c_start_busy", 32'(ic.busy), 1);
    ic.start = 1'b0;
    ic.match = 1'b1;
    step();
    chk("c_busy", 32'(ic.busy), 0);
    chk("c_valid", 32'(ic.result_valid), 1);
    chk("c_result", 32'(ic.result), 1);
    chk("c_alarm", 32'(ic.alarm), 0);
    ic.match = 1'b0;
    ic.ack = 1'b1;
    step();
    chk("c_ack_valid", 32'(ic.result_valid), 0);
    ic.ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snail_match_counter.md
# snail_match_counter

Windowed match counter that sits directly downstream of the serial 010 sequence detector and consumes its registered one-cycle match output. On a start request it counts detector matches over a fixed window of clock cycles. It then latches the total and a threshold alarm into a result register. The result is held with a valid/ack handshake until the consumer (status logic or CPU-side register block) takes it.

## Interface
- CNT_W, 8, width of match count and result; count saturates at 2^CNT_W-1
- WINDOW, 64, length of the counting window in clock cycles; legal range 1..65535
- THRESH, 3, alarm threshold; alarm when result >= THRESH
- clk  input  1  system clock, all state updates on posedge
- _rst  input  1  asynchronous active-low reset
- match  input  1  match flag from the sequence detector (its Q), sampled on posedge clk
- start  input  1  request to begin a window; honoured only in IDLE
- ack  input  1  consumer acknowledge of result; honoured only in DONE
- busy  output  1  high while in RUN
- result_valid  output  1  high while in DONE
- result  output  CNT_W  count latched at end of window
- alarm  output  1  registered (result >= THRESH), updated together with result

## Operation
- States: IDLE, RUN, DONE. Two-bit state register, async reset to IDLE.
- IDLE: start=1 -> RUN. The match counter and window counter clear to 0 on this edge. Otherwise stay in IDLE.
- RUN: on each edge, add the match event to the counter (saturating) and increment the window counter. When window counter == WINDOW-1, go to DONE on that edge.
  - On that same edge: result <= counter + event of that cycle (saturated); alarm <= (that value >= THRESH).
- DONE: ack=1 -> IDLE. Otherwise hold. The match input is ignored.
- start in RUN or DONE is ignored and is not queued.
- start and ack both high in DONE: ack wins, go to IDLE, start is dropped. A new start is needed in IDLE.
- result and alarm keep their values after leaving DONE until the next window completes.
- Saturation: the counter never wraps; it sticks at all-ones until cleared by the next start.
- Window counter width: clog2(WINDOW), minimum 1 bit. WINDOW=1 means exactly one RUN cycle.
- Reset asserted mid-operation: immediate return to IDLE. All outputs and internal counters go to 0, and any partial count is lost.

## Timing
- Reset values: busy=0, result_valid=0, result=0, alarm=0, state=IDLE, edge-detect register=0.
- If start is sampled at edge k:
  - busy is high from k until edge k+WINDOW.
  - match is sampled at edges k+1 .. k+WINDOW.
  - result_valid rises at edge k+WINDOW.
- ack sampled at edge j in DONE: result_valid falls at edge j, and start is accepted at edge j+1 at the earliest.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- SNAIL_CNT_EDGE_EN defined: an event is a rising edge of match (match=1 and previous-cycle match=0). The previous-cycle register tracks match in every state.
- SNAIL_CNT_EDGE_EN undefined: an event is every cycle with match=1 (level counting).
- The two modes give identical results for a well-formed detector stream, where match is never high two cycles in a row.

## Test plan
- Reset: drive _rst low mid-cycle with random inputs -> outputs 0 immediately and busy=0. After release, no activity until start.
- WINDOW=16, THRESH=3: start, then match pulses at RUN cycles 0, 5 and 15 -> result_valid rises 16 edges after the start edge, with result=3 and alarm=1.
- CNT_W=4, WINDOW=32: match held high for the whole window -> result=15 (saturated) without the macro; result=1 with SNAIL_CNT_EDGE_EN.
- In DONE, hold ack=0 for 10 cycles while toggling start and match -> result, alarm and result_valid are unchanged. Then assert ack and start together -> IDLE with start dropped. start on the next cycle -> RUN.
- Reset asserted at RUN cycle 7 after 2 matches, then a new start plus 1 match -> result=1. The old count must not carry over.
- WINDOW=1: start, with match=1 at the single RUN cycle -> result=1 and result_valid 1 edge after the start edge. With THRESH=3, alarm=0.
